toccata_pb_fifo_ctrl: RTL and testbench

//  Playback FIFO controller between the Zorro register write path and the playback sequencer.
//  - Owns the FIFO pointers, fill level and prime/run sequencing.
//  - Arbitrates host byte writes against sequencer reads and flush requests.
//  - Raises the half-empty interrupt plus sticky overrun and underrun status.

---
 rtl/toccata_pkg.sv | 15 +
 rtl/toccata_pb_fifo_ctrl_if.sv | 38 +++
 rtl/toccata_fifo_ram.sv | 31 +++
 rtl/toccata_pb_fifo_ctrl.sv | 123 ++++++++++++
 tb/tb_toccata_pb_fifo_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/toccata_pkg.sv
// Toccata playback FIFO shared types and constants.
// Imported by the FIFO controller and its RAM.
package toccata_pkg;

   localparam int TOCCATA_FIFO_DEPTH = 1024;
   localparam logic [7:0] DATA_IDLE = 8'h80;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRIME,
      S_RUN,
      S_FLUSH
   } fifo_state_t;

endpackage

// File: rtl/toccata_pb_fifo_ctrl_if.sv
// Toccata playback FIFO bus: host writes, sequencer reads,
// control strobes and status flags.
interface toccata_pb_fifo_ctrl_if #(
   parameter int DEPTH = toccata_pkg::TOCCATA_FIFO_DEPTH
);
   localparam int AW = $clog2(DEPTH);

   logic          pen;
   logic          host_flush;
   logic          wr_stb;
   logic [7:0]    wr_data;
   logic          rst_fifo;
   logic          rd_en;
   logic [7:0]    data_out;
   logic          empty;
   logic          full;
   logic [AW:0]   level;
   logic          irq_half;
   logic          irq_ack;
   logic          overrun;
   logic          underrun;
   logic          stat_clr;

   modport master (
      output pen, host_flush, wr_stb, wr_data,
      output rst_fifo, rd_en, irq_ack, stat_clr,
      input  data_out, empty, full, level,
      input  irq_half, overrun, underrun
   );

   modport slave (
      input  pen, host_flush, wr_stb, wr_data,
      input  rst_fifo, rd_en, irq_ack, stat_clr,
      output data_out, empty, full, level,
      output irq_half, overrun, underrun
   );

endinterface

// File: rtl/toccata_fifo_ram.sv
// Simple dual-port byte RAM for the playback FIFO.
// One write port, one registered read port.
module toccata_fifo_ram
   import toccata_pkg::*;
#(
   parameter int DEPTH = TOCCATA_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Same-address write and read (full FIFO) returns the old byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= DATA_IDLE;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/toccata_pb_fifo_ctrl.sv
// Playback FIFO controller: pointers, fill level,
// prime/run sequencing and interrupt/status flags.
module toccata_pb_fifo_ctrl
   import toccata_pkg::*;
#(
   parameter int DEPTH       = TOCCATA_FIFO_DEPTH,
   parameter int HALF_LEVEL  = DEPTH / 2,
   parameter int PRIME_LEVEL = DEPTH / 2
) (
   input logic clk,
   input logic rst_n,
   toccata_pb_fifo_ctrl_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [AW:0] LVL_HALF  = LW'(HALF_LEVEL);
   localparam logic [AW:0] LVL_PRIME = LW'(PRIME_LEVEL);

   fifo_state_t   state_q, state_d;
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   level_q, level_d;
   logic          empty_q, empty_d;
   logic          hi_q, irq_q, ovr_q, udr_q;
   logic          flush_req, full;
   logic          wr_acc, rd_acc;
   logic          wr_drop, rd_under, half_evt;

   assign flush_req = bus.rst_fifo | bus.host_flush;
   assign full      = (level_q == LVL_FULL);

   // A read at full frees its slot for a same-cycle write.
   assign rd_acc  = bus.rd_en & ~empty_q & ~flush_req;
   assign wr_acc  = bus.wr_stb & (~full | rd_acc) & ~flush_req
                  & (state_q != S_FLUSH);
   assign wr_drop = bus.wr_stb & full & ~rd_acc & ~flush_req;

   assign rd_under = bus.rd_en & empty_q & ~flush_req
                   & (state_q == S_RUN);
   assign half_evt = hi_q & (level_q < LVL_HALF)
                   & (state_q == S_RUN);

   always_comb begin
      level_d = level_q;
      unique case (1'b1)
         flush_req:         level_d = '0;
         wr_acc & ~rd_acc:  level_d = level_q + 1'b1;
         rd_acc & ~wr_acc:  level_d = level_q - 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (flush_req) begin
         state_d = S_FLUSH;
      end else begin
         unique case (state_q)
            S_IDLE:  if (bus.pen) state_d = S_PRIME;
            S_PRIME: begin
               if (!bus.pen)                state_d = S_IDLE;
               else if (level_q >= LVL_PRIME) state_d = S_RUN;
            end
            S_RUN:   if (!bus.pen) state_d = S_IDLE;
            S_FLUSH: state_d = bus.pen ? S_PRIME : S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
      empty_d = (state_d != S_RUN) | (level_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         empty_q <= 1'b1;
         hi_q    <= 1'b0;
         irq_q   <= 1'b0;
         ovr_q   <= 1'b0;
         udr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         empty_q <= empty_d;
         hi_q    <= (level_q >= LVL_HALF);
         if (flush_req) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            if (wr_acc) wptr_q <= wptr_q + 1'b1;
            if (rd_acc) rptr_q <= rptr_q + 1'b1;
         end
         irq_q <= half_evt | (irq_q & ~bus.irq_ack);
         ovr_q <= wr_drop  | (ovr_q & ~bus.stat_clr);
         udr_q <= rd_under | (udr_q & ~bus.stat_clr);
      end
   end

   toccata_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wptr_q),
      .wdata (bus.wr_data),
      .re    (rd_acc),
      .raddr (rptr_q),
      .rdata (bus.data_out)
   );

   assign bus.empty    = empty_q;
   assign bus.full     = full;
   assign bus.level    = level_q;
   assign bus.irq_half = irq_q;
   assign bus.overrun  = ovr_q;
   assign bus.underrun = udr_q;

endmodule

// File: tb/tb_toccata_pb_fifo_ctrl.sv
// Bench for the playback FIFO controller: byte-queue model
// checked every cycle plus directed literal expectations.
module tb_toccata_pb_fifo_ctrl;
   import toccata_pkg::*;

   localparam int DEPTH = TOCCATA_FIFO_DEPTH;
   localparam int HALF  = DEPTH / 2;
   localparam int PRIME = DEPTH / 2;
   localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_FLUSH = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   toccata_pb_fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();

   toccata_pb_fifo_ctrl #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int wk    = 0;

   logic [7:0] mq [$];
   int         m_mode  = M_IDLE;
   bit         m_empty = 1'b1;
   logic [7:0] m_dout  = 8'h80;
   bit         m_irq   = 1'b0;
   bit         m_ovr   = 1'b0;
   bit         m_udr   = 1'b0;
   int         m_prev  = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input int k);
      return 8'((k * 37 + 5) & 255);
   endfunction

   // Model: the FIFO contents are a queue of bytes.
   task automatic model_step();
      int lvl, nm;
      bit fl, rd, wr, oe, ue, he;
      if (!rst_n) begin
         mq.delete();
         m_mode = M_IDLE; m_empty = 1'b1; m_dout = 8'h80;
         m_irq = 1'b0; m_ovr = 1'b0; m_udr = 1'b0; m_prev = 0;
         return;
      end
      lvl = mq.size();
      fl  = bus.rst_fifo | bus.host_flush;
      he  = (m_mode == M_RUN) && (m_prev >= HALF) && (lvl < HALF);
      m_prev = lvl;
      rd = 0; wr = 0; oe = 0; ue = 0;
      if (!fl) begin
         rd = bus.rd_en && !m_empty;
         ue = bus.rd_en && m_empty && (m_mode == M_RUN);
         wr = bus.wr_stb && (m_mode != M_FLUSH) && (lvl < DEPTH || rd);
         oe = bus.wr_stb && (lvl == DEPTH) && !rd;
      end
      if (rd) m_dout = mq.pop_front();
      if (wr) mq.push_back(bus.wr_data);
      if (fl) mq.delete();
      nm = m_mode;
      if (fl) nm = M_FLUSH;
      else case (m_mode)
         M_IDLE:  if (bus.pen) nm = M_PRIME;
         M_PRIME: if (!bus.pen) nm = M_IDLE;
                  else if (lvl >= PRIME) nm = M_RUN;
         M_RUN:   if (!bus.pen) nm = M_IDLE;
         default: nm = bus.pen ? M_PRIME : M_IDLE;
      endcase
      m_mode  = nm;
      m_empty = (nm != M_RUN) || (mq.size() == 0);
      m_irq   = he || (m_irq && !bus.irq_ack);
      m_ovr   = oe || (m_ovr && !bus.stat_clr);
      m_udr   = ue || (m_udr && !bus.stat_clr);
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("m_data_out", bus.data_out, m_dout);
         chk("m_empty", bus.empty, m_empty);
         chk("m_full", bus.full, mq.size() == DEPTH);
         chk("m_level", bus.level, mq.size());
         chk("m_irq_half", bus.irq_half, m_irq);
         chk("m_overrun", bus.overrun, m_ovr);
         chk("m_underrun", bus.underrun, m_udr);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr1(input logic [7:0] d);
      bus.wr_stb = 1'b1; bus.wr_data = d;
      cyc();
      bus.wr_stb = 1'b0;
   endtask

   task automatic wr_burst(input int n);
      bus.wr_stb = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.wr_data = byte_of(wk);
         wk++;
         cyc();
      end
      bus.wr_stb = 1'b0;
   endtask

   task automatic rdn(input int n);
      bus.rd_en = 1'b1;
      repeat (n) cyc();
      bus.rd_en = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.irq_ack = 1'b1; cyc(); bus.irq_ack = 1'b0;
   endtask

   task automatic pulse_clr();
      bus.stat_clr = 1'b1; cyc(); bus.stat_clr = 1'b0;
   endtask

   initial begin
      bus.pen = 0; bus.host_flush = 0; bus.wr_stb = 0;
      bus.wr_data = 0; bus.rst_fifo = 0; bus.rd_en = 0;
      bus.irq_ack = 0; bus.stat_clr = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_level", bus.level, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_dout", bus.data_out, 8'h80);
      chk("rst_irq", bus.irq_half, 0);
      chk("rst_flags", {bus.overrun, bus.underrun}, 0);

      // pen low: writes land, nothing is released
      wr1(8'h11); wr1(8'h22); wr1(8'h33);
      chk("idle_level", bus.level, 3);
      chk("idle_empty", bus.empty, 1);
      rdn(1);
      chk("idle_rd_level", bus.level, 3);
      chk("idle_rd_udr", bus.underrun, 0);
      chk("idle_rd_dout", bus.data_out, 8'h80);
      bus.host_flush = 1'b1; cyc(); bus.host_flush = 1'b0;
      chk("hflush_level", bus.level, 0);

      // prime to 512, then run
      bus.pen = 1'b1; cyc();
      wr_burst(511);
      chk("prime_level", bus.level, 511);
      chk("prime_empty", bus.empty, 1);
      wr_burst(1);
      chk("prime512_level", bus.level, 512);
      chk("prime512_empty", bus.empty, 1);
      cyc();
      chk("run_empty", bus.empty, 0);
      rdn(1);
      chk("first_dout", bus.data_out, 8'd5);
      chk("first_level", bus.level, 511);
      chk("irq_not_yet", bus.irq_half, 0);
      cyc();
      chk("irq_set", bus.irq_half, 1);
      pulse_ack();
      chk("irq_acked", bus.irq_half, 0);
      rdn(1); cyc();
      chk("irq_no_reset", bus.irq_half, 0);
      chk("second_dout", bus.data_out, 8'd42);

      // fill to full, overrun, write+read at full
      wr_burst(514);
      chk("full_flag", bus.full, 1);
      chk("full_level", bus.level, 1024);
      wr1(8'hEE);
      chk("ovr_set", bus.overrun, 1);
      chk("ovr_level", bus.level, 1024);
      pulse_clr();
      chk("ovr_clr", bus.overrun, 0);
      bus.wr_stb = 1'b1; bus.wr_data = byte_of(wk); bus.rd_en = 1'b1;
      wk++;
      cyc();
      bus.wr_stb = 1'b0; bus.rd_en = 1'b0;
      chk("wr_rd_full_level", bus.level, 1024);
      chk("wr_rd_full_ovr", bus.overrun, 0);
      chk("wr_rd_full_dout", bus.data_out, 8'd79);

      // half-empty crossing from the top
      rdn(512);
      chk("at_half_level", bus.level, 512);
      chk("at_half_irq", bus.irq_half, 0);
      rdn(1);
      chk("below_half_level", bus.level, 511);
      chk("below_half_irq0", bus.irq_half, 0);
      cyc();
      chk("below_half_irq1", bus.irq_half, 1);
      pulse_ack();

      // drain and underrun
      rdn(511);
      chk("drain_level", bus.level, 0);
      chk("drain_empty", bus.empty, 1);
      chk("drain_dout", bus.data_out, 8'd79);
      rdn(1);
      chk("udr_set", bus.underrun, 1);
      chk("udr_dout", bus.data_out, 8'd79);
      pulse_clr();
      chk("udr_clr", bus.underrun, 0);

      // sequencer flush with a colliding write
      wr_burst(700);
      chk("pre_flush_level", bus.level, 700);
      bus.rst_fifo = 1'b1; bus.wr_stb = 1'b1; bus.wr_data = 8'hAA;
      cyc();
      bus.rst_fifo = 1'b0; bus.wr_stb = 1'b0;
      chk("flush_level", bus.level, 0);
      chk("flush_ovr", bus.overrun, 0);
      chk("flush_empty", bus.empty, 1);
      rdn(1);
      chk("flush_rd_udr", bus.underrun, 0);
      wr_burst(512);
      chk("reprime_empty", bus.empty, 1);
      cyc();
      chk("reprime_run", bus.empty, 0);

      // pen drop keeps the data
      bus.pen = 1'b0; cyc();
      chk("pen_off_empty", bus.empty, 1);
      chk("pen_off_level", bus.level, 512);

      // async reset mid-cycle
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_level", bus.level, 0);
      chk("arst_empty", bus.empty, 1);
      chk("arst_full", bus.full, 0);
      chk("arst_dout", bus.data_out, 8'h80);
      chk("arst_flags", {bus.irq_half, bus.overrun, bus.underrun}, 0);
      #20;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
